// File: rtl/stack_rpn_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stack_rpn_alu: RPN evaluator that sequences push/pop on a byte stack.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stack_rpn_alu #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [2:0]               op_code,
  input  logic [WIDTH-1:0]         op_imm,
  output logic                     result_valid,
  output logic [WIDTH-1:0]         result,
  output logic                     carry,
  output logic                     error,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     stk_push,
  output logic                     stk_pop,
  output logic [WIDTH-1:0]         stk_wdata,
  input  logic [WIDTH-1:0]         stk_rdata,
  input  logic                     stk_done
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_PUSHI = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_DUP   = 3'b110;
  localparam logic [2:0] OP_POP   = 3'b111;

  localparam logic [1:0] ERR_UNF = 2'd1;
  localparam logic [1:0] ERR_OVF = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_POP_B  = 4'd1,
    S_WAIT_B = 4'd2,
    S_POP_A  = 4'd3,
    S_WAIT_A = 4'd4,
    S_EXEC   = 4'd5,
    S_PUSH_R = 4'd6,
    S_WAIT_R = 4'd7,
    S_DONE   = 4'd8,
    S_ERR    = 4'd9
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q, op_nxt;
  logic [WIDTH-1:0] a_q, a_nxt;
  logic [WIDTH-1:0] b_q, b_nxt;
  logic [WIDTH-1:0] wdata_q, wdata_nxt;
  logic [WIDTH-1:0] res_q, res_nxt;
  logic             carry_q, carry_nxt;
  logic             pcarry_q, pcarry_nxt;
  logic [1:0]       ecode_q, ecode_nxt;
  logic [DW-1:0]    depth_q, depth_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             dup2_q, dup2_nxt;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             timed_out;
  logic             stk_empty;
  logic             stk_full;

  assign sum       = {1'b0, a_q} + {1'b0, b_q};
  assign diff      = {1'b0, a_q} - {1'b0, b_q};
  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));
  assign stk_empty = (depth_q == '0);
  assign stk_full  = (depth_q >= DW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      wdata_q  <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      pcarry_q <= 1'b0;
      ecode_q  <= '0;
      depth_q  <= '0;
      cnt_q    <= '0;
      dup2_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      op_q     <= op_nxt;
      a_q      <= a_nxt;
      b_q      <= b_nxt;
      wdata_q  <= wdata_nxt;
      res_q    <= res_nxt;
      carry_q  <= carry_nxt;
      pcarry_q <= pcarry_nxt;
      ecode_q  <= ecode_nxt;
      depth_q  <= depth_nxt;
      cnt_q    <= cnt_nxt;
      dup2_q   <= dup2_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    op_nxt     = op_q;
    a_nxt      = a_q;
    b_nxt      = b_q;
    wdata_nxt  = wdata_q;
    res_nxt    = res_q;
    carry_nxt  = carry_q;
    pcarry_nxt = pcarry_q;
    ecode_nxt  = ecode_q;
    depth_nxt  = depth_q;
    cnt_nxt    = cnt_q;
    dup2_nxt   = dup2_q;

    case (state)
      // Legality is decided here so a rejected op never touches the stack.
      S_IDLE: begin
        if (op_valid) begin
          op_nxt   = op_code;
          dup2_nxt = 1'b0;
          case (op_code)
            OP_NOP: state_nxt = S_DONE;
            OP_PUSHI: begin
              if (stk_full) begin
                state_nxt = S_ERR;
                ecode_nxt = ERR_OVF;
              end else begin
                wdata_nxt = op_imm;
                state_nxt = S_PUSH_R;
              end
            end
            OP_DUP: begin
              if (stk_empty) begin
                state_nxt = S_ERR;
                ecode_nxt = ERR_UNF;
              end else if (stk_full) begin
                state_nxt = S_ERR;
                ecode_nxt = ERR_OVF;
              end else begin
                state_nxt = S_POP_B;
              end
            end
            OP_POP: begin
              if (stk_empty) begin
                state_nxt = S_ERR;
                ecode_nxt = ERR_UNF;
              end else begin
                state_nxt = S_POP_B;
              end
            end
            default: begin
              if (depth_q < DW'(2)) begin
                state_nxt = S_ERR;
                ecode_nxt = ERR_UNF;
              end else begin
                state_nxt = S_POP_B;
              end
            end
          endcase
        end
      end

      S_POP_B: begin
        state_nxt = S_WAIT_B;
        cnt_nxt   = '0;
      end

      S_WAIT_B: begin
        if (stk_done) begin
          depth_nxt = depth_q - DW'(1);
          b_nxt     = stk_rdata;
          case (op_q)
            OP_POP: begin
              res_nxt   = stk_rdata;
              state_nxt = S_DONE;
            end
            OP_DUP: begin
              wdata_nxt = stk_rdata;
              state_nxt = S_PUSH_R;
            end
            default: state_nxt = S_POP_A;
          endcase
        end else if (timed_out) begin
          state_nxt = S_ERR;
          ecode_nxt = ERR_TMO;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end

      S_POP_A: begin
        state_nxt = S_WAIT_A;
        cnt_nxt   = '0;
      end

      S_WAIT_A: begin
        if (stk_done) begin
          depth_nxt = depth_q - DW'(1);
          a_nxt     = stk_rdata;
          state_nxt = S_EXEC;
        end else if (timed_out) begin
          state_nxt = S_ERR;
          ecode_nxt = ERR_TMO;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end

      // Carry is staged and only committed once the result push completes.
      S_EXEC: begin
        state_nxt = S_PUSH_R;
        case (op_q)
          OP_ADD: begin
            wdata_nxt  = sum[WIDTH-1:0];
            pcarry_nxt = sum[WIDTH];
          end
          OP_SUB: begin
            wdata_nxt  = diff[WIDTH-1:0];
            pcarry_nxt = diff[WIDTH];
          end
          OP_AND:  wdata_nxt = a_q & b_q;
          default: wdata_nxt = a_q ^ b_q;
        endcase
      end

      S_PUSH_R: begin
        state_nxt = S_WAIT_R;
        cnt_nxt   = '0;
      end

      S_WAIT_R: begin
        if (stk_done) begin
          depth_nxt = depth_q + DW'(1);
          if ((op_q == OP_DUP) && !dup2_q) begin
            dup2_nxt  = 1'b1;
            state_nxt = S_PUSH_R;
          end else begin
            res_nxt   = wdata_q;
            state_nxt = S_DONE;
            if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
              carry_nxt = pcarry_q;
            end
          end
        end else if (timed_out) begin
          state_nxt = S_ERR;
          ecode_nxt = ERR_TMO;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end

      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign op_ready     = (state == S_IDLE);
  assign result_valid = (state == S_DONE);
  assign error        = (state == S_ERR);
  assign stk_pop      = (state == S_POP_B) || (state == S_POP_A);
  assign stk_push     = (state == S_PUSH_R);
  assign stk_wdata    = wdata_q;
  assign result       = res_q;
  assign carry        = carry_q;
  assign err_code     = ecode_q;
  assign depth        = depth_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_rpn_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stack_rpn_alu: self-checking bench with a latency-programmable stack. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_stack_rpn_alu;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSHI = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_AND   = 3'd4;
  localparam logic [2:0] OP_XOR   = 3'd5;
  localparam logic [2:0] OP_DUP   = 3'd6;
  localparam logic [2:0] OP_POP   = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_code;
  logic [7:0] op_imm;
  logic       result_valid;
  logic [7:0] result;
  logic       carry;
  logic       error;
  logic [1:0] err_code;
  logic [4:0] depth;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_wdata;
  logic [7:0] stk_rdata;
  logic       stk_done;

  stack_rpn_alu #(.WIDTH(8), .DEPTH(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_imm(op_imm), .result_valid(result_valid),
    .result(result), .carry(carry), .error(error), .err_code(err_code),
    .depth(depth), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata), .stk_done(stk_done)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Stack responder state
  logic [7:0] mem [16];
  int         sp = 0;
  int         pend = 0;
  logic       pend_pop = 1'b0;
  logic [7:0] pend_wd = '0;
  int         lat = 1;
  bit         hang = 1'b0;
  bit         stray_req = 1'b0;
  int         ev_q[$];
  int         bad_both = 0;
  int         bad_wd = 0;

  // Reference model state
  logic [7:0] ref_q[$];
  logic [7:0] ref_res = '0;
  logic       ref_carry = 1'b0;
  logic [1:0] ref_ecode = '0;

  // Per-op capture
  logic       cap_rv, cap_err, cap_carry, cap_ready1, cap_ready_after, cap_got;
  logic [7:0] cap_res;
  logic [1:0] cap_ecode;
  logic [4:0] cap_depth;
  int         cap_k, cap_ev;

  typedef struct {
    logic [2:0] code;
    logic [7:0] imm;
    logic       err;
    logic [1:0] ecode;
    logic [7:0] res;
    logic       cy;
    int         dep;
    int         ev;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int ev_since(input int start);
    int v = 0;
    for (int i = start; i < ev_q.size(); i++) v = v * 10 + ev_q[i];
    return v;
  endfunction

  // Stack model: 1 = pop, 2 = push recorded in ev_q
  initial begin
    stk_done  = 1'b0;
    stk_rdata = '0;
    forever begin
      @(negedge clk);
      stk_done = 1'b0;
      if (!rst_n) begin
        pend = 0;
        sp   = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            stk_done = 1'b1;
            if (pend_pop) begin
              if (sp > 0) sp--;
              stk_rdata = mem[sp];
            end else begin
              if (stk_wdata !== pend_wd) bad_wd++;
              if (sp < 16) begin
                mem[sp] = stk_wdata;
                sp++;
              end
            end
          end
        end
        if (stray_req) begin
          stk_done  = 1'b1;
          stk_rdata = 8'($urandom);
        end
        if (stk_push && stk_pop) bad_both++;
        if (stk_push || stk_pop) begin
          ev_q.push_back(stk_pop ? 1 : 2);
          if (!hang) begin
            pend     = lat;
            pend_pop = stk_pop;
            pend_wd  = stk_wdata;
          end
        end
      end
    end
  end

  // Behavioural evaluator over a queue; returns error flag and expected traffic
  function automatic void model(input logic [2:0] code, input logic [7:0] imm,
                                output logic e, output int ev);
    int a, b, r;
    e  = 1'b0;
    ev = 0;
    case (code)
      OP_NOP: ;
      OP_PUSHI: begin
        if (ref_q.size() >= 16) begin e = 1'b1; ref_ecode = 2'd2; end
        else begin ref_q.push_back(imm); ref_res = imm; ev = 2; end
      end
      OP_DUP: begin
        if (ref_q.size() < 1) begin e = 1'b1; ref_ecode = 2'd1; end
        else if (ref_q.size() >= 16) begin e = 1'b1; ref_ecode = 2'd2; end
        else begin ref_res = ref_q[$]; ref_q.push_back(ref_res); ev = 122; end
      end
      OP_POP: begin
        if (ref_q.size() < 1) begin e = 1'b1; ref_ecode = 2'd1; end
        else begin ref_res = ref_q.pop_back(); ev = 1; end
      end
      default: begin
        if (ref_q.size() < 2) begin e = 1'b1; ref_ecode = 2'd1; end
        else begin
          b = int'(ref_q.pop_back());
          a = int'(ref_q.pop_back());
          case (code)
            OP_ADD: begin r = a + b; ref_carry = (r > 255); r = r % 256; end
            OP_SUB: begin ref_carry = (a < b); r = (a - b + 256) % 256; end
            OP_AND: r = a & b;
            default: r = a ^ b;
          endcase
          ref_res = 8'(r);
          ref_q.push_back(ref_res);
          ev = 112;
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [2:0] code, input logic [7:0] imm);
    int start;
    @(negedge clk);
    for (int k = 0; k < 50 && !op_ready; k++) @(negedge clk);
    chk("op_ready_idle", op_ready, 1);
    start    = ev_q.size();
    op_valid = 1'b1;
    op_code  = code;
    op_imm   = imm;
    @(negedge clk);
    op_valid   = 1'b0;
    op_code    = 3'($urandom);
    op_imm     = 8'($urandom);
    cap_k      = 1;
    cap_ready1 = op_ready;
    cap_got    = 1'b0;
    while (!cap_got && cap_k < 100) begin
      if (result_valid || error) cap_got = 1'b1;
      else begin
        @(negedge clk);
        cap_k++;
      end
    end
    chk("op_complete", cap_got, 1);
    cap_rv    = result_valid;
    cap_err   = error;
    cap_res   = result;
    cap_carry = carry;
    cap_ecode = err_code;
    cap_depth = depth;
    @(negedge clk);
    cap_ready_after = op_ready;
    cap_ev          = ev_since(start);
  endtask

  task automatic model_op(input logic [2:0] code, input logic [7:0] imm);
    logic e;
    int   ev;
    run_op(code, imm);
    model(code, imm, e, ev);
    chk("pulse_rv_err", {cap_rv, cap_err}, e ? 2'b01 : 2'b10);
    chk("result", cap_res, ref_res);
    chk("carry", cap_carry, ref_carry);
    chk("depth", cap_depth, ref_q.size());
    chk("err_code", cap_ecode, ref_ecode);
    chk("stack_traffic", cap_ev, ev);
    chk("ready_low_after_accept", cap_ready1, 0);
    chk("ready_back", cap_ready_after, 1);
  endtask

  initial begin
    int   npop, k, snap;
    logic e;
    int   ev;

    tbl[0]  = '{OP_PUSHI, 8'h05, 1'b0, 2'd0, 8'h05, 1'b0, 1, 2};
    tbl[1]  = '{OP_PUSHI, 8'h03, 1'b0, 2'd0, 8'h03, 1'b0, 2, 2};
    tbl[2]  = '{OP_SUB,   8'h00, 1'b0, 2'd0, 8'h02, 1'b0, 1, 112};
    tbl[3]  = '{OP_POP,   8'h00, 1'b0, 2'd0, 8'h02, 1'b0, 0, 1};
    tbl[4]  = '{OP_PUSHI, 8'hF0, 1'b0, 2'd0, 8'hF0, 1'b0, 1, 2};
    tbl[5]  = '{OP_PUSHI, 8'h20, 1'b0, 2'd0, 8'h20, 1'b0, 2, 2};
    tbl[6]  = '{OP_ADD,   8'h00, 1'b0, 2'd0, 8'h10, 1'b1, 1, 112};
    tbl[7]  = '{OP_PUSHI, 8'h20, 1'b0, 2'd0, 8'h20, 1'b1, 2, 2};
    tbl[8]  = '{OP_SUB,   8'h00, 1'b0, 2'd0, 8'hF0, 1'b1, 1, 112};
    tbl[9]  = '{OP_AND,   8'h00, 1'b1, 2'd1, 8'hF0, 1'b1, 1, 0};
    tbl[10] = '{OP_PUSHI, 8'h0F, 1'b0, 2'd0, 8'h0F, 1'b1, 2, 2};
    tbl[11] = '{OP_XOR,   8'h00, 1'b0, 2'd0, 8'hFF, 1'b1, 1, 112};
    tbl[12] = '{OP_DUP,   8'h00, 1'b0, 2'd0, 8'hFF, 1'b1, 2, 122};
    tbl[13] = '{OP_AND,   8'h00, 1'b0, 2'd0, 8'hFF, 1'b1, 1, 112};
    tbl[14] = '{OP_NOP,   8'h00, 1'b0, 2'd0, 8'hFF, 1'b1, 1, 0};
    tbl[15] = '{OP_POP,   8'h00, 1'b0, 2'd0, 8'hFF, 1'b1, 0, 1};
    tbl[16] = '{OP_POP,   8'h00, 1'b1, 2'd1, 8'hFF, 1'b1, 0, 0};
    tbl[17] = '{OP_DUP,   8'h00, 1'b1, 2'd1, 8'hFF, 1'b1, 0, 0};
    tbl[18] = '{OP_PUSHI, 8'h7F, 1'b0, 2'd0, 8'h7F, 1'b1, 1, 2};
    tbl[19] = '{OP_PUSHI, 8'h81, 1'b0, 2'd0, 8'h81, 1'b1, 2, 2};
    tbl[20] = '{OP_ADD,   8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 1, 112};
    tbl[21] = '{OP_PUSHI, 8'h01, 1'b0, 2'd0, 8'h01, 1'b1, 2, 2};
    tbl[22] = '{OP_SUB,   8'h00, 1'b0, 2'd0, 8'hFF, 1'b1, 1, 112};
    tbl[23] = '{OP_PUSHI, 8'hFF, 1'b0, 2'd0, 8'hFF, 1'b1, 2, 2};
    tbl[24] = '{OP_SUB,   8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1, 112};
    tbl[25] = '{OP_POP,   8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 0, 1};

    rst_n    = 1'b0;
    op_valid = 1'b0;
    op_code  = '0;
    op_imm   = '0;
    repeat (3) @(negedge clk);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_error", error, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_depth", depth, 0);
    chk("rst_stk_req", {stk_push, stk_pop}, 0);
    chk("rst_stk_wdata", stk_wdata, 0);
    #1 rst_n = 1'b1;

    // Directed table with a 1-cycle stack
    lat = 1;
    foreach (tbl[i]) begin
      run_op(tbl[i].code, tbl[i].imm);
      model(tbl[i].code, tbl[i].imm, e, ev);
      chk($sformatf("tbl%0d_pulse", i), {cap_rv, cap_err}, tbl[i].err ? 2'b01 : 2'b10);
      chk($sformatf("tbl%0d_result", i), cap_res, tbl[i].res);
      chk($sformatf("tbl%0d_carry", i), cap_carry, tbl[i].cy);
      chk($sformatf("tbl%0d_depth", i), cap_depth, tbl[i].dep);
      chk($sformatf("tbl%0d_traffic", i), cap_ev, tbl[i].ev);
      chk($sformatf("tbl%0d_ready_low", i), cap_ready1, 0);
      chk($sformatf("tbl%0d_ready_back", i), cap_ready_after, 1);
      if (tbl[i].err) begin
        chk($sformatf("tbl%0d_err_code", i), cap_ecode, tbl[i].ecode);
        chk($sformatf("tbl%0d_err_latency", i), cap_k, 1);
      end
      if (tbl[i].code == OP_NOP) chk($sformatf("tbl%0d_nop_latency", i), cap_k, 1);
    end

    // Fill to capacity, then overflow on PUSHI and DUP
    lat = 2;
    for (int i = 0; i < 16; i++) model_op(OP_PUSHI, 8'($urandom));
    model_op(OP_PUSHI, 8'hAA);
    chk("ovf_pushi_code", cap_ecode, 2);
    chk("ovf_pushi_traffic", cap_ev, 0);
    chk("ovf_pushi_depth", cap_depth, 16);
    model_op(OP_DUP, 8'h00);
    chk("ovf_dup_code", cap_ecode, 2);
    for (int i = 0; i < 16; i++) model_op(OP_POP, 8'h00);

    // Stack never answers a pop
    model_op(OP_PUSHI, 8'h11);
    hang = 1'b1;
    run_op(OP_POP, 8'h00);
    hang = 1'b0;
    ref_ecode = 2'd3;
    chk("tmo_pulse", {cap_rv, cap_err}, 2'b01);
    chk("tmo_latency", cap_k, 17);
    chk("tmo_err_code", cap_ecode, 3);
    chk("tmo_depth", cap_depth, 1);
    model_op(OP_PUSHI, 8'h22);

    // Asynchronous reset while waiting on the second pop
    lat = 4;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = OP_ADD;
    @(negedge clk);
    op_valid = 1'b0;
    npop = 0;
    k    = 0;
    while (npop < 2 && k < 40) begin
      if (stk_pop) npop++;
      if (npop < 2) begin
        @(negedge clk);
        k++;
      end
    end
    chk("reached_pop_a", npop, 2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_op_ready", op_ready, 1);
    chk("arst_pulses", {result_valid, error}, 0);
    chk("arst_result", result, 0);
    chk("arst_carry", carry, 0);
    chk("arst_err_code", err_code, 0);
    chk("arst_depth", depth, 0);
    chk("arst_stk_req", {stk_push, stk_pop}, 0);
    chk("arst_stk_wdata", stk_wdata, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    ref_q.delete();
    ref_res   = '0;
    ref_carry = 1'b0;
    ref_ecode = '0;
    snap      = ev_q.size();
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    #1 stray_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_depth", depth, 0);
    chk("stray_no_requests", ev_q.size(), snap);
    chk("stray_op_ready", op_ready, 1);
    model_op(OP_PUSHI, 8'h5A);

    // Randomized ops against the queue model
    for (int i = 0; i < 300; i++) begin
      logic [2:0] c;
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, (i < 150) ? 1 : 3) == 0) c = OP_PUSHI;
      else c = 3'($urandom_range(0, 7));
      model_op(c, 8'($urandom));
    end

    chk("push_pop_overlap", bad_both, 0);
    chk("wdata_unstable", bad_wd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
